doppler_tx_burst: RTL and testbench
===================================

DOPPLER_TX_BURST -- requirements
Module: doppler_tx_burst

Interface
REQ-001 SHALL have port DEMODCLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port ENABLE, input, 1 bit: run request, level-sensitive.
REQ-004 SHALL have port BURSTCYCLES, input, 8 bits: carrier periods per burst; 0 is treated as 1.
REQ-005 SHALL have port PRFPERIOD, input, 16 bits: clocks from one burst start to the next.
REQ-006 SHALL have port GATEDELAY, input, 16 bits: clocks from burst start to the opening of the receive gate.
REQ-007 SHALL have port GATELENGTH, input, 16 bits: receive gate width in clocks; 0 means no gate.
REQ-008 SHALL have port TXP, output, 1 bit: positive pulser drive.
REQ-009 SHALL have port TXN, output, 1 bit: negative pulser drive.
REQ-010 SHALL have port DEMODEN, output, 1 bit: drives the demodulator ENABLE.
REQ-011 SHALL have port BURSTSTART, output, 1 bit: one-clock strobe on the first clock of each burst.
REQ-012 SHALL have port BUSY, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port PULSECOUNT, output, 16 bits: count of bursts since reset; wraps from 0xFFFF to 0.

Function
REQ-014 SHALL implement four states: IDLE, TX, LISTEN, HOLDOFF.
REQ-015 SHALL run a 16-bit period counter PC; PC = 0 on the first burst clock and increments by 1 per clock.
REQ-016 SHALL latch BURSTCYCLES, PRFPERIOD, GATEDELAY and GATELENGTH into shadow registers on entry to TX; changes during a period are ignored.
REQ-017 SHALL define N = max(BURSTCYCLES, 1), B = 8*N and effective period P = max(PRFPERIOD, B+1).
REQ-018 SHALL, in IDLE with ENABLE=1 at a rising edge, enter TX on the next clock with PC=0, BURSTSTART=1 and PULSECOUNT incremented (1-clock latency).
REQ-019 SHALL, in TX, drive TXP=1 for PC mod 8 in 0..3 and TXN=1 for PC mod 8 in 4..7; carrier period is 8 clocks, phase-aligned to the demodulator's 3-bit quadrature index.
REQ-020 SHALL never assert TXP and TXN in the same clock, and SHALL hold both at 0 outside TX.
REQ-021 SHALL leave TX for LISTEN after PC = B-1; a burst is never truncated.
REQ-022 SHALL, in LISTEN, move to HOLDOFF when PC >= GATEDELAY+GATELENGTH (17-bit compare), or at PC = P-2 if that comes first.
REQ-023 SHALL, in HOLDOFF, at PC = P-1 either enter TX with PC=0 (ENABLE=1) or return to IDLE (ENABLE=0).
REQ-024 SHALL assert DEMODEN iff GATELENGTH != 0, GATEDELAY <= PC < GATEDELAY+GATELENGTH, and PC < P-1; the gate may overlap TX.
REQ-025 SHALL keep DEMODEN low for at least the last clock of every period, so the demodulator returns to its init state between gates.
REQ-026 SHALL, on ENABLE falling mid-period, complete the current period (burst and gate) and then return to IDLE; no partial carrier cycle is permitted.
REQ-027 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-028 SHALL, on RESET assertion, asynchronously force: state=IDLE, PC=0, TXP=0, TXN=0, DEMODEN=0, BURSTSTART=0, BUSY=0, PULSECOUNT=0, shadow registers=0.
REQ-029 SHALL, on RESET asserted mid-burst, drop TXP/TXN immediately with no completion, and SHALL start a new burst only after RESET is low and ENABLE is sampled high in IDLE.

Structure
REQ-030 SHALL place state encoding, CARRIER_LOG2=3, carrier period 8 and the DELAY define in the shared defines package.
REQ-031 SHALL instantiate one sub-module, burst_carrier, which takes a phase enable and the 3-bit PC[2:0] and produces registered TXP/TXN.

Verification
REQ-032 SHALL cover: RESET, then ENABLE=1, BURSTCYCLES=2, PRFPERIOD=40, GATEDELAY=20, GATELENGTH=8 -> TXP high PC 0-3 and 8-11, TXN high PC 4-7 and 12-15, DEMODEN high PC 20-27, BURSTSTART at PC 0 and again 40 clocks later.
REQ-033 SHALL cover: BURSTCYCLES=0, PRFPERIOD=4 -> one carrier cycle (8 clocks), effective period 9, BURSTSTART every 9 clocks.
REQ-034 SHALL cover: GATEDELAY=30, GATELENGTH=20, PRFPERIOD=40 -> DEMODEN high PC 30-38, low at PC 39.
REQ-035 SHALL cover: ENABLE dropped at PC=5 of a 2-cycle burst -> full 16-clock burst and gate complete, then IDLE with BUSY=0 at PC=P.
REQ-036 SHALL cover: RESET pulsed at PC=6 -> TXP/TXN/DEMODEN are 0 before the next edge and PULSECOUNT=0.
REQ-037 SHALL cover: 65536 bursts -> PULSECOUNT wraps to 0, and TXP&TXN=0 is checked on every clock.

Source files
------------

// File: rtl/doppler_tx_burst_pkg.sv
// Shared definitions for the Doppler transmit burst sequencer.
// State encoding, carrier geometry and period helpers.
package doppler_tx_burst_pkg;

    localparam int CARRIER_LOG2   = 3;
    localparam int CARRIER_PERIOD = 1 << CARRIER_LOG2;
    // Clocks from ENABLE sampled in IDLE to the first burst clock.
    localparam int DELAY          = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX      = 2'd1,
        LISTEN  = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]  cycles;
        logic [15:0] prf;
        logic [15:0] gdly;
        logic [15:0] glen;
    } shadow_t;

    // Burst length in clocks: max(cycles,1) carrier periods.
    function automatic logic [15:0] burst_len(shadow_t s);
        logic [15:0] n;
        n = {8'd0, s.cycles};
        if (n == 16'd0) n = 16'd1;
        return n * 16'(CARRIER_PERIOD);
    endfunction

    // Period never shorter than burst plus one quiet clock.
    function automatic logic [15:0] eff_period(shadow_t s);
        logic [15:0] b;
        b = burst_len(s);
        return (s.prf > b) ? s.prf : b + 16'd1;
    endfunction

    // End of receive gate, one bit wider so it cannot wrap.
    function automatic logic [16:0] gate_end(shadow_t s);
        return {1'b0, s.gdly} + {1'b0, s.glen};
    endfunction

endpackage

// File: rtl/doppler_tx_burst_carrier.sv
// Carrier generator: registered push-pull drive from the
// 3-bit period phase; both legs low when not enabled.
module burst_carrier
    import doppler_tx_burst_pkg::*;
(
    input  logic                    DEMODCLK,
    input  logic                    RESET,
    input  logic                    phase_en,
    input  logic [CARRIER_LOG2-1:0] phase,
    output logic                    TXP,
    output logic                    TXN
);

    // First half of each carrier period drives TXP, second TXN.
    always_ff @(posedge DEMODCLK or posedge RESET) begin
        if (RESET) begin
            TXP <= 1'b0;
            TXN <= 1'b0;
        end else begin
            TXP <= phase_en & ~phase[CARRIER_LOG2-1];
            TXN <= phase_en &  phase[CARRIER_LOG2-1];
        end
    end

endmodule

// File: rtl/doppler_tx_burst.sv
// Doppler transmit burst sequencer: burst, receive gate and
// pulse repetition timing with registered outputs.
module doppler_tx_burst
    import doppler_tx_burst_pkg::*;
(
    input  logic        DEMODCLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [7:0]  BURSTCYCLES,
    input  logic [15:0] PRFPERIOD,
    input  logic [15:0] GATEDELAY,
    input  logic [15:0] GATELENGTH,
    output logic        TXP,
    output logic        TXN,
    output logic        DEMODEN,
    output logic        BURSTSTART,
    output logic        BUSY,
    output logic [15:0] PULSECOUNT
);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    shadow_t     sh_q, sh_d;
    logic        start;
    logic        dem_d;
    logic        busy_d;

    logic [15:0] b_len;
    logic [15:0] p_len;
    logic [16:0] g_end;
    logic        last;

    logic [15:0] p_len_d;
    logic [16:0] g_end_d;

    assign b_len = burst_len(sh_q);
    assign p_len = eff_period(sh_q);
    assign g_end = gate_end(sh_q);
    assign last  = (pc_q == p_len - 16'd1);

    // State, period counter and shadow configuration.
    always_ff @(posedge DEMODCLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= 16'd0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sh_q    <= sh_d;
        end
    end

    // Next state; ENABLE only matters in IDLE and at period end.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q + 16'd1;
        sh_d    = sh_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                pc_d  = 16'd0;
                start = ENABLE;
            end
            TX: begin
                if (pc_q == b_len - 16'd1) state_d = LISTEN;
            end
            LISTEN: begin
                if (last) begin
                    start = ENABLE;
                    if (!ENABLE) begin
                        state_d = IDLE;
                        pc_d    = 16'd0;
                    end
                end else if ({1'b0, pc_q} >= g_end ||
                             pc_q >= p_len - 16'd2) begin
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (last) begin
                    start = ENABLE;
                    if (!ENABLE) begin
                        state_d = IDLE;
                        pc_d    = 16'd0;
                    end
                end
            end
        endcase
        if (start) begin
            state_d = TX;
            pc_d    = 16'd0;
            sh_d    = '{BURSTCYCLES, PRFPERIOD,
                        GATEDELAY, GATELENGTH};
        end
    end

    assign p_len_d = eff_period(sh_d);
    assign g_end_d = gate_end(sh_d);

    // Output decode from the upcoming state so outputs align with PC.
    always_comb begin
        busy_d = (state_d != IDLE);
        dem_d  = busy_d &&
                 (sh_d.glen != 16'd0) &&
                 (pc_d >= sh_d.gdly) &&
                 ({1'b0, pc_d} < g_end_d) &&
                 (pc_d < p_len_d - 16'd1);
    end

    // Registered status outputs and burst counter.
    always_ff @(posedge DEMODCLK or posedge RESET) begin
        if (RESET) begin
            DEMODEN    <= 1'b0;
            BURSTSTART <= 1'b0;
            BUSY       <= 1'b0;
            PULSECOUNT <= 16'd0;
        end else begin
            DEMODEN    <= dem_d;
            BURSTSTART <= start;
            BUSY       <= busy_d;
            PULSECOUNT <= PULSECOUNT + {15'd0, start};
        end
    end

    burst_carrier u_carrier (
        .DEMODCLK (DEMODCLK),
        .RESET    (RESET),
        .phase_en (state_d == TX),
        .phase    (pc_d[CARRIER_LOG2-1:0]),
        .TXP      (TXP),
        .TXN      (TXN)
    );

endmodule

// File: tb/tb_doppler_tx_burst.sv
// Testbench for doppler_tx_burst: table of configurations
// checked clock by clock through an expected-value queue.
module tb_doppler_tx_burst;
    import doppler_tx_burst_pkg::*;

    logic        DEMODCLK;
    logic        RESET;
    logic        ENABLE;
    logic [7:0]  BURSTCYCLES;
    logic [15:0] PRFPERIOD;
    logic [15:0] GATEDELAY;
    logic [15:0] GATELENGTH;
    logic        TXP;
    logic        TXN;
    logic        DEMODEN;
    logic        BURSTSTART;
    logic        BUSY;
    logic [15:0] PULSECOUNT;

    doppler_tx_burst dut (
        .DEMODCLK   (DEMODCLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
        .BURSTCYCLES(BURSTCYCLES),
        .PRFPERIOD  (PRFPERIOD),
        .GATEDELAY  (GATEDELAY),
        .GATELENGTH (GATELENGTH),
        .TXP        (TXP),
        .TXN        (TXN),
        .DEMODEN    (DEMODEN),
        .BURSTSTART (BURSTSTART),
        .BUSY       (BUSY),
        .PULSECOUNT (PULSECOUNT)
    );

    initial DEMODCLK = 1'b0;
    always #5 DEMODCLK = ~DEMODCLK;

    typedef struct packed {
        logic        txp;
        logic        txn;
        logic        dem;
        logic        bs;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic [7:0]  bc;
        logic [15:0] prf;
        logic [15:0] gd;
        logic [15:0] gl;
        int          per;
        int          blen;
        int          glo;
        int          ghi;
    } vec_t;

    vec_t        vt[7];
    exp_t        sb[$];
    int          n_chk;
    int          n_fail;
    logic [15:0] exp_count;

    function automatic exp_t sample();
        return {TXP, TXN, DEMODEN, BURSTSTART, BUSY, PULSECOUNT};
    endfunction

    function automatic exp_t mk(int k, vec_t c, logic [15:0] cnt);
        exp_t e;
        e.txp  = (k < c.blen) && ((k % 8) < 4);
        e.txn  = (k < c.blen) && ((k % 8) >= 4);
        e.dem  = (k >= c.glo) && (k < c.ghi);
        e.bs   = (k == 0);
        e.busy = 1'b1;
        e.cnt  = cnt;
        return e;
    endfunction

    function automatic exp_t idle_e(logic [15:0] cnt);
        exp_t e;
        e = '0;
        e.cnt = cnt;
        return e;
    endfunction

    task automatic check(string nm, exp_t act, exp_t want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got txp=%b txn=%b dem=%b bs=%b busy=%b cnt=%h, want txp=%b txn=%b dem=%b bs=%b busy=%b cnt=%h",
                     nm, act.txp, act.txn, act.dem, act.bs, act.busy, act.cnt,
                     want.txp, want.txn, want.dem, want.bs, want.busy, want.cnt);
        end
    endtask

    task automatic apply_cfg(vec_t c);
        BURSTCYCLES = c.bc;
        PRFPERIOD   = c.prf;
        GATEDELAY   = c.gd;
        GATELENGTH  = c.gl;
    endtask

    // Runs one or two periods of vector v; ENABLE drops at drop_k.
    task automatic run_vec(int v, int drop_k);
        vec_t c;
        int   nper;
        int   n;
        exp_t a;
        exp_t e;
        c = vt[v];
        apply_cfg(c);
        ENABLE = 1'b1;
        nper = (drop_k < c.per) ? 1 : 2;
        for (int p = 0; p < nper; p++) begin
            exp_count++;
            for (int k = 0; k < c.per; k++)
                sb.push_back(mk(k, c, exp_count));
        end
        sb.push_back(idle_e(exp_count));
        sb.push_back(idle_e(exp_count));
        repeat (DELAY - 1) @(negedge DEMODCLK);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge DEMODCLK);
            a = sample();
            e = sb.pop_front();
            check($sformatf("v%0d_k%0d", v, i), a, e);
            if (i == 2) begin
                BURSTCYCLES = 8'($urandom);
                PRFPERIOD   = 16'($urandom);
                GATEDELAY   = 16'($urandom);
                GATELENGTH  = 16'($urandom);
            end
            if (i == c.per - 3) apply_cfg(c);
            if (i == drop_k) ENABLE = 1'b0;
        end
    endtask

    initial begin
        exp_t a;
        exp_t e;
        int   bursts;
        int   last_bs;
        bit   done;

        n_chk = 0;
        n_fail = 0;
        exp_count = 16'd0;
        vt[0] = '{8'd2, 16'd40,     16'd20, 16'd8,      40, 16, 20, 28};
        vt[1] = '{8'd0, 16'd4,      16'd0,  16'd0,       9,  8,  0,  0};
        vt[2] = '{8'd1, 16'd40,     16'd30, 16'd20,     40,  8, 30, 39};
        vt[3] = '{8'd3, 16'd30,     16'd2,  16'd5,      30, 24,  2,  7};
        vt[4] = '{8'd4, 16'd10,     16'd0,  16'd100,    33, 32,  0, 32};
        vt[5] = '{8'd1, 16'd12,     16'd5,  16'd0,      12,  8,  0,  0};
        vt[6] = '{8'd1, 16'd20, 16'hFFF0,  16'h0020,    20,  8,  0,  0};

        RESET = 1'b1;
        ENABLE = 1'b0;
        apply_cfg(vt[0]);
        #2;
        check("reset_async", sample(), idle_e(16'd0));
        repeat (2) @(negedge DEMODCLK);
        check("reset_held", sample(), idle_e(16'd0));
        RESET = 1'b0;
        @(negedge DEMODCLK);
        check("idle_no_enable", sample(), idle_e(16'd0));

        for (int v = 0; v < 7; v++)
            run_vec(v, vt[v].per);

        run_vec(0, 5);

        apply_cfg(vt[0]);
        ENABLE = 1'b1;
        exp_count++;
        for (int k = 0; k < 7; k++)
            sb.push_back(mk(k, vt[0], exp_count));
        for (int k = 0; k < 7; k++) begin
            @(negedge DEMODCLK);
            a = sample();
            e = sb.pop_front();
            check($sformatf("pre_rst_k%0d", k), a, e);
        end
        #1 RESET = 1'b1;
        #1;
        exp_count = 16'd0;
        check("rst_mid_burst", sample(), idle_e(16'd0));
        @(negedge DEMODCLK);
        check("rst_mid_hold", sample(), idle_e(16'd0));
        RESET = 1'b0;
        run_vec(0, 0);

        @(negedge DEMODCLK);
        RESET = 1'b1;
        @(negedge DEMODCLK);
        RESET = 1'b0;
        exp_count = 16'd0;
        BURSTCYCLES = 8'd0;
        PRFPERIOD   = 16'd0;
        GATEDELAY   = 16'd0;
        GATELENGTH  = 16'd0;
        ENABLE = 1'b1;
        bursts = 0;
        last_bs = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 65536 * 9 + 64 && !done; cyc++) begin
            @(negedge DEMODCLK);
            n_chk++;
            if (TXP & TXN) begin
                n_fail++;
                $display("FAIL wrap_excl cyc%0d: got txp=%b txn=%b, want not both", cyc, TXP, TXN);
            end
            if (BURSTSTART) begin
                bursts++;
                if (bursts > 1) begin
                    n_chk++;
                    if (cyc - last_bs != 9) begin
                        n_fail++;
                        $display("FAIL wrap_interval: got %0d, want 9", cyc - last_bs);
                    end
                end
                last_bs = cyc;
                if (bursts == 65535) begin
                    n_chk++;
                    if (PULSECOUNT !== 16'hFFFF) begin
                        n_fail++;
                        $display("FAIL wrap_max: got %h, want ffff", PULSECOUNT);
                    end
                end
                if (bursts == 65536) begin
                    n_chk++;
                    if (PULSECOUNT !== 16'h0000) begin
                        n_fail++;
                        $display("FAIL wrap_zero: got %h, want 0000", PULSECOUNT);
                    end
                    ENABLE = 1'b0;
                    done = 1'b1;
                end
            end
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL wrap_timeout: got %0d bursts, want 65536", bursts);
        end
        repeat (12) @(negedge DEMODCLK);
        check("wrap_idle", sample(), idle_e(16'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
